// File: rtl/argmax_sequencer_if.sv
// Bundles the start/result handshake, the score-buffer read port and the shared comparator
// port of the argmax sequencer. The sequencer uses the slave view.
interface argmax_sequencer_if #(
    parameter int RESOLUTION = 8,
    parameter int INDEX_SIZE = 4
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [INDEX_SIZE-1:0] digit;
    logic [RESOLUTION-1:0] max_score;

    logic                  score_rd;
    logic [INDEX_SIZE-1:0] score_addr;
    logic [RESOLUTION-1:0] score_data;

    logic [RESOLUTION-1:0] cmp_in1;
    logic [INDEX_SIZE-1:0] cmp_idx1;
    logic [RESOLUTION-1:0] cmp_in2;
    logic [INDEX_SIZE-1:0] cmp_idx2;
    logic [RESOLUTION-1:0] cmp_max_val;
    logic [INDEX_SIZE-1:0] cmp_max_idx;

    modport slave (
        input  start, score_data, cmp_max_val, cmp_max_idx,
        output busy, done, digit, max_score, score_rd, score_addr,
               cmp_in1, cmp_idx1, cmp_in2, cmp_idx2
    );

    modport master (
        output start, score_data, cmp_max_val, cmp_max_idx,
        input  busy, done, digit, max_score, score_rd, score_addr,
               cmp_in1, cmp_idx1, cmp_in2, cmp_idx2
    );
endinterface

// File: rtl/argmax_sequencer.sv
// Scans N_CLASSES scores through one shared 1-cycle comparator, feeding back the running
// maximum, and reports the winning index/score with a single-cycle done pulse.
module argmax_sequencer #(
    parameter int N_CLASSES  = 10,
    parameter int RESOLUTION = 8,
    parameter int INDEX_SIZE = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    argmax_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [INDEX_SIZE-1:0] LAST_IDX = INDEX_SIZE'(N_CLASSES - 1);
    localparam logic [INDEX_SIZE-1:0] ONE_IDX  = INDEX_SIZE'(1);

    state_t                state_q;
    logic                  busy_q;
    logic                  rd_q;
    logic [INDEX_SIZE-1:0] addr_q;
    logic                  done_q;
    logic [INDEX_SIZE-1:0] digit_q;
    logic [RESOLUTION-1:0] max_q;
    // cmp_*: compare in flight this cycle; res_*: its result now on cmp_max_*
    logic                  cmp_v_q;
    logic [INDEX_SIZE-1:0] cmp_k_q;
    logic                  res_v_q;
    logic [INDEX_SIZE-1:0] res_k_q;

    logic [RESOLUTION-1:0] cmp_in1_d;
    logic [INDEX_SIZE-1:0] cmp_idx1_d;
    logic [RESOLUTION-1:0] cmp_in2_d;
    logic [INDEX_SIZE-1:0] cmp_idx2_d;

    // Sequencer FSM, read-address counter, compare pipeline valids and result capture
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            digit_q <= '0;
            max_q   <= '0;
            cmp_v_q <= 1'b0;
            cmp_k_q <= '0;
            res_v_q <= 1'b0;
            res_k_q <= '0;
        end else begin
            cmp_v_q <= rd_q;
            cmp_k_q <= addr_q;
            res_v_q <= cmp_v_q;
            res_k_q <= cmp_k_q;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q <= S_FETCH;
                        busy_q  <= 1'b1;
                        rd_q    <= 1'b1;
                        addr_q  <= '0;
                    end
                end
                S_FETCH: begin
                    if (addr_q == LAST_IDX) begin
                        rd_q    <= 1'b0;
                        state_q <= S_DRAIN;
                    end else begin
                        addr_q <= addr_q + ONE_IDX;
                    end
                end
                S_DRAIN: begin
                    // The comparator result for the last index is visible now
                    if (res_v_q && (res_k_q == LAST_IDX)) begin
                        digit_q <= bus.cmp_max_idx;
                        max_q   <= bus.cmp_max_val;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Comparator operands: first compare seeds against zero, later ones feed back the running max
    always_comb begin
        cmp_in1_d  = '0;
        cmp_idx1_d = '0;
        cmp_in2_d  = '0;
        cmp_idx2_d = '0;
        if (cmp_v_q) begin
            cmp_in2_d  = bus.score_data;
            cmp_idx2_d = cmp_k_q;
            if (cmp_k_q == '0) begin
                cmp_in1_d  = '0;
                cmp_idx1_d = '0;
            end else begin
                cmp_in1_d  = bus.cmp_max_val;
                cmp_idx1_d = bus.cmp_max_idx;
            end
        end else begin
            cmp_in1_d  = '0;
            cmp_idx1_d = '0;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.digit      = digit_q;
    assign bus.max_score  = max_q;
    assign bus.score_rd   = rd_q;
    assign bus.score_addr = addr_q;
    assign bus.cmp_in1    = cmp_in1_d;
    assign bus.cmp_idx1   = cmp_idx1_d;
    assign bus.cmp_in2    = cmp_in2_d;
    assign bus.cmp_idx2   = cmp_idx2_d;
endmodule

// File: tb/tb_argmax_sequencer.sv
// Bench for argmax_sequencer: score buffer and comparator models, a table of directed scans,
// chained/ignored-start and mid-scan reset sequences, and randomized scans vs. an argmax model.
module tb_argmax_sequencer;
    localparam int N   = 10;
    localparam int RES = 8;
    localparam int IDX = 4;

    typedef logic [N-1:0][RES-1:0] scores_t;
    typedef struct {
        string          name;
        scores_t        sc;
        logic [IDX-1:0] d;
        logic [RES-1:0] m;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_mis = 0;
    logic [RES-1:0] mem [N];

    always #5 clk = ~clk;

    argmax_sequencer_if #(.RESOLUTION(RES), .INDEX_SIZE(IDX)) bus ();

    argmax_sequencer #(.N_CLASSES(N), .RESOLUTION(RES), .INDEX_SIZE(IDX)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    // Score buffer: one-cycle read latency
    always @(posedge clk) begin
        if (bus.score_rd) bus.score_data <= mem[bus.score_addr];
    end

    // Shared comparator: registered, tie keeps in1
    always @(posedge clk) begin
        if (reset) begin
            bus.cmp_max_val <= '0;
            bus.cmp_max_idx <= '0;
        end else if (bus.cmp_in2 > bus.cmp_in1) begin
            bus.cmp_max_val <= bus.cmp_in2;
            bus.cmp_max_idx <= bus.cmp_idx2;
        end else begin
            bus.cmp_max_val <= bus.cmp_in1;
            bus.cmp_max_idx <= bus.cmp_idx1;
        end
    end

    task automatic check(input string nm, input bit ok, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (!ok) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // Reference: first index holding the largest score
    task automatic ref_argmax(input scores_t sc, output logic [IDX-1:0] d, output logic [RES-1:0] m);
        d = '0;
        m = sc[0];
        for (int i = 1; i < N; i++) begin
            if (sc[i] > m) begin
                m = sc[i];
                d = IDX'(i);
            end
        end
    endtask

    function automatic scores_t fill(input logic [RES-1:0] v);
        scores_t s;
        for (int i = 0; i < N; i++) s[i] = v;
        return s;
    endfunction

    // One scan from the cycle after a previous done (or idle); ends at the negedge of the done cycle
    task automatic run_scan(input string name, input scores_t sc, input logic [IDX-1:0] ed,
                            input logic [RES-1:0] em, input bit spam);
        bit rd_ok = 1'b1, busy_ok = 1'b1, feed_ok = 1'b1, done_ok = 1'b1;
        logic [31:0] rd_g = '0, rd_e = '0, busy_g = '0, feed_g = '0, feed_e = '0, done_g = '0;
        logic [RES-1:0] rm = '0;
        logic [IDX-1:0] ri = '0;
        logic [31:0] g, e;
        int k;
        @(negedge clk);
        check({name, "_idle"}, (bus.busy === 1'b0) && (bus.done === 1'b0),
              32'({bus.busy, bus.done}), 32'd0);
        for (int i = 0; i < N; i++) mem[i] = sc[i];
        bus.start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= N + 3; c++) begin
            @(negedge clk);
            if (!spam) bus.start = 1'b0;
            g = 32'({bus.score_rd, bus.score_addr});
            e = (c <= N) ? 32'({1'b1, IDX'(c - 1)}) : 32'({1'b0, IDX'(N - 1)});
            if (g !== e && rd_ok) begin rd_ok = 1'b0; rd_g = g; rd_e = e; end
            if (bus.busy !== (c <= N + 2) && busy_ok) begin
                busy_ok = 1'b0; busy_g = 32'(c);
            end
            if (bus.done !== (c == N + 3) && done_ok) begin
                done_ok = 1'b0; done_g = 32'(c);
            end
            g = {bus.cmp_in1, bus.cmp_idx1, bus.cmp_in2, bus.cmp_idx2};
            if (c >= 2 && c <= N + 1) begin
                k = c - 2;
                e = {rm, ri, sc[k], IDX'(k)};
                if (k == 0 || sc[k] > rm) begin rm = sc[k]; ri = IDX'(k); end
            end else begin
                e = '0;
            end
            if (g !== e && feed_ok) begin feed_ok = 1'b0; feed_g = g; feed_e = e; end
        end
        check({name, "_rd_addr"}, rd_ok, rd_g, rd_e);
        check({name, "_busy_cycle"}, busy_ok, busy_g, 32'd0);
        check({name, "_done_cycle"}, done_ok, done_g, 32'd0);
        check({name, "_cmp_feed"}, feed_ok, feed_g, feed_e);
        check({name, "_digit"}, bus.digit === ed, 32'(bus.digit), 32'(ed));
        check({name, "_max_score"}, bus.max_score === em, 32'(bus.max_score), 32'(em));
    endtask

    vec_t           tbl [6];
    scores_t        s;
    logic [IDX-1:0] rd_d;
    logic [RES-1:0] rd_m;
    bit             quiet;

    initial begin
        bus.start = 1'b0;
        reset     = 1'b1;
        for (int i = 0; i < N; i++) mem[i] = '0;

        tbl[0].name = "ramp_peak7";
        tbl[0].sc   = {8'd100, 8'd90, 8'd200, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
        tbl[0].d    = 4'd7;  tbl[0].m = 8'd200;
        s = fill(8'd5); s[3] = 8'd99; s[8] = 8'd99;
        tbl[1].name = "tie_3_8";  tbl[1].sc = s; tbl[1].d = 4'd3; tbl[1].m = 8'd99;
        tbl[2].name = "all_zero"; tbl[2].sc = fill(8'd0); tbl[2].d = 4'd0; tbl[2].m = 8'd0;
        s = fill(8'd254); s[9] = 8'd255;
        tbl[3].name = "max_last"; tbl[3].sc = s; tbl[3].d = 4'd9; tbl[3].m = 8'd255;
        tbl[4].name = "all_255";  tbl[4].sc = fill(8'd255); tbl[4].d = 4'd0; tbl[4].m = 8'd255;
        s = fill(8'd100); s[0] = 8'd200;
        tbl[5].name = "max_first"; tbl[5].sc = s; tbl[5].d = 4'd0; tbl[5].m = 8'd200;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {bus.busy, bus.done, bus.score_rd, bus.score_addr, bus.digit, bus.max_score} === '0,
              32'({bus.busy, bus.done, bus.score_rd, bus.score_addr, bus.digit, bus.max_score}), 32'd0);
        reset = 1'b0;

        for (int v = 0; v < 6; v++) run_scan(tbl[v].name, tbl[v].sc, tbl[v].d, tbl[v].m, 1'b0);

        // start held high through a scan and its done cycle, then accepted on done+1
        run_scan("start_spam", tbl[0].sc, tbl[0].d, tbl[0].m, 1'b1);
        run_scan("chain_after_done", tbl[1].sc, tbl[1].d, tbl[1].m, 1'b0);
        run_scan("prime_nonzero", tbl[0].sc, tbl[0].d, tbl[0].m, 1'b0);

        // Reset in the middle of a scan
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        check("midscan_busy", bus.busy === 1'b1, 32'(bus.busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midscan_reset_busy", bus.busy === 1'b0, 32'(bus.busy), 32'd0);
        check("midscan_reset_rd", bus.score_rd === 1'b0, 32'(bus.score_rd), 32'd0);
        check("midscan_reset_digit", {bus.digit, bus.max_score} === '0,
              32'({bus.digit, bus.max_score}), 32'd0);
        reset = 1'b0;
        quiet = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
        end
        check("midscan_no_done", quiet, 32'({bus.done, bus.busy}), 32'd0);
        run_scan("after_reset", tbl[3].sc, tbl[3].d, tbl[3].m, 1'b0);

        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < N; i++)
                s[i] = (r % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(250, 253));
            ref_argmax(s, rd_d, rd_m);
            run_scan($sformatf("rand%0d", r), s, rd_d, rd_m, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
